prod_acc: RTL and testbench
===========================

Name: prod_acc

Overview:
- Downstream consumer of the shift-add multiplier's product word.
- Accepts unsigned products over a valid/ready handshake and accumulates N_TERMS of them, or fewer if flushed, into a wide saturating accumulator.
- Presents the sum, term count and overflow flag on an output valid/ready handshake.
- Forms the dot-product / MAC stage behind the multiplier.

Parameters:
- PW, 32, product input width (multiplier product width).
- AW, 40, accumulator/result width; must satisfy AW >= PW.
- N_TERMS, 4, products per accumulation; must be >= 1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  in_product is valid this cycle.
- in_ready  output  1  block can accept a product this cycle.
- in_product  input  PW  unsigned product from the multiplier.
- flush  input  1  close the current accumulation early.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_sum  output  AW  accumulated sum.
- out_count  output  $clog2(N_TERMS+1)  number of terms in out_sum.
- out_ovf  output  1  sum saturated during this accumulation.

Behaviour:
- Single clock domain. The only reset is rst: synchronous, active-high.
- Reset values: state=ACC, acc=0, cnt=0, ovf=0, in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
- rst asserted in any state, including mid-accumulation or while HOLD waits on out_ready, discards all partial results next edge. No output is produced for the aborted accumulation.
- States:
  - ACC: accumulating. in_ready=1, out_valid=0.
  - HOLD: result presented. in_ready=0, out_valid=1.
- Input handshake:
  - A beat is accepted when in_valid && in_ready at a rising edge.
  - in_product is zero-extended to AW+1 bits and added to acc.
  - If the (AW+1)-bit sum exceeds 2^AW-1: acc <= all ones, ovf <= 1 (sticky until the result is consumed). Otherwise acc <= sum.
  - Once saturated, acc stays all ones for further beats.
  - cnt increments per accepted beat.
- Transition ACC->HOLD, on the edge where either:
  - a beat is accepted and cnt+1 == N_TERMS, or
  - flush=1 and (a beat is accepted, or cnt>0).
- On that edge: out_sum <= post-update acc, out_count <= post-update cnt, out_ovf <= post-update ovf, out_valid <= 1.
  - Latency: result visible the cycle after the final beat.
- flush=1 in ACC with cnt==0 and no beat accepted: ignored. Empty results are never emitted.
- flush in HOLD: ignored (not remembered).
- HOLD: out_sum/out_count/out_ovf held stable while out_valid=1 and out_ready=0. in_valid ignored; the upstream stalls.
- HOLD->ACC on out_ready=1. Same edge: acc<=0, cnt<=0, ovf<=0, out_valid<=0, in_ready<=1.
  - No bypass: a beat offered during the handshake cycle is not accepted; it is taken on the following cycle.
- out_sum/out_count/out_ovf keep their last values after consumption; they are meaningful only while out_valid=1.
- Minimum throughput: one result per N_TERMS+1 cycles with out_ready tied high.
- Registered outputs only; no combinational path from in_valid/out_ready to in_ready/out_valid.

Test Plan:
- Reset, then 4 back-to-back beats 0x10, 0x20, 0x30, 0x40 with out_ready=1 -> cycle after 4th beat: out_valid=1, out_sum=0xA0, out_count=4, out_ovf=0. in_ready=0 that cycle, 1 the next.
- Backpressure: same 4 beats, out_ready=0 for 5 cycles, in_valid held high with 0x55 -> out_sum stays 0xA0, in_ready=0 throughout, no 0x55 absorbed. After out_ready pulse, next accepted beat starts a new sum at 0x55.
- Flush: beats 0x7, 0x9, then flush=1 with in_valid=0 -> out_sum=0x10, out_count=2. Flush with a concurrent beat 0x1 after one beat 0x2 -> out_sum=0x3, out_count=2. Flush with cnt=0 -> no out_valid.
- Overflow with AW=33, PW=32, N_TERMS=4: beats 0xFFFFFFFF x3, 0x5 -> out_sum=0x1FFFFFFFF, out_ovf=1, out_count=4. Following accumulation of 0x1 x4 -> out_sum=0x4, out_ovf=0.
- Reset mid-operation: 2 beats accepted, rst=1 for one cycle -> out_valid=0, in_ready=1. Then 4 beats of 0x1 -> out_sum=0x4, out_count=4. Repeat with rst asserted while in HOLD -> out_valid drops the next edge.
- N_TERMS=1: every accepted beat X -> out_valid next cycle with out_sum=X, out_count=1. Random in_valid/out_ready over 1000 beats -> scoreboard sums match, no beat lost or duplicated.

Source files
------------

// File: rtl/prod_acc_if.sv
// Product-accumulator handshake bundle.
// Master feeds products and consumes results; slave is the accumulator.
interface prod_acc_if #(
  parameter int PW = 32,
  parameter int AW = 40,
  parameter int CW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_product;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic [CW-1:0] out_count;
  logic          out_ovf;

  modport master (
    output in_valid,
    output in_product,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_count,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  in_product,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_count,
    output out_ovf
  );
endinterface

// File: rtl/prod_acc.sv
// Saturating MAC stage: sums N_TERMS products (or fewer on flush)
// and holds the result until the consumer takes it.
module prod_acc #(
  parameter int PW      = 32,
  parameter int AW      = 40,
  parameter int N_TERMS = 4
) (
  input logic       clk,
  input logic       rst,
  prod_acc_if.slave bus
);
  localparam int CW = $clog2(N_TERMS + 1);

  typedef enum logic {
    ACC,
    HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] osum_q, osum_d;
  logic [CW-1:0] ocnt_q, ocnt_d;
  logic          oovf_q, oovf_d;

  logic          beat;
  logic          done;
  logic [AW:0]   sum_w;
  logic [AW-1:0] acc_upd;
  logic [CW-1:0] cnt_upd;
  logic          ovf_upd;

  // Carry out of the widened add marks saturation.
  always_comb begin
    beat    = bus.in_valid && (state_q == ACC);
    sum_w   = {1'b0, acc_q} + (AW+1)'(bus.in_product);
    acc_upd = acc_q;
    ovf_upd = ovf_q;
    cnt_upd = cnt_q;
    if (beat) begin
      acc_upd = sum_w[AW] ? '1 : sum_w[AW-1:0];
      ovf_upd = ovf_q | sum_w[AW];
      cnt_upd = cnt_q + CW'(1);
    end
    done = (beat && (cnt_upd == CW'(N_TERMS)))
        || (bus.flush && (beat || (cnt_q != '0)));
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    osum_d  = osum_q;
    ocnt_d  = ocnt_q;
    oovf_d  = oovf_q;
    unique case (state_q)
      ACC: begin
        acc_d = acc_upd;
        cnt_d = cnt_upd;
        ovf_d = ovf_upd;
        if (done) begin
          state_d = HOLD;
          osum_d  = acc_upd;
          ocnt_d  = cnt_upd;
          oovf_d  = ovf_upd;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      osum_q  <= '0;
      ocnt_q  <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      osum_q  <= osum_d;
      ocnt_q  <= ocnt_d;
      oovf_q  <= oovf_d;
    end
  end

  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = osum_q;
  assign bus.out_count = ocnt_q;
  assign bus.out_ovf   = oovf_q;
endmodule

// File: tb/tb_prod_acc.sv
// Bench for prod_acc: directed scenarios plus randomized
// traffic against a queue-based reference of grouped sums.
module tb_prod_acc;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  prod_acc_if #(.PW(32), .AW(40), .CW(3)) b0 ();
  prod_acc_if #(.PW(32), .AW(33), .CW(3)) b1 ();
  prod_acc_if #(.PW(32), .AW(40), .CW(1)) b2 ();

  prod_acc #(.PW(32), .AW(40), .N_TERMS(4)) u0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  prod_acc #(.PW(32), .AW(33), .N_TERMS(4)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  prod_acc #(.PW(32), .AW(40), .N_TERMS(1)) u2 (
    .clk(clk), .rst(rst), .bus(b2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b0.in_valid = 0; b0.in_product = '0;
    b0.flush = 0; b0.out_ready = 0;
    b1.in_valid = 0; b1.in_product = '0;
    b1.flush = 0; b1.out_ready = 0;
    b2.in_valid = 0; b2.in_product = '0;
    b2.flush = 0; b2.out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle();
    tick();
    tick();
    checks++;
    if (b0.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", b0.in_ready);
    end
    checks++;
    if (b0.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b exp=0", b0.out_valid);
    end
    checks++;
    if (b0.out_sum !== 40'd0) begin
      failures++;
      $display("FAIL reset_out_sum got=%h exp=0", b0.out_sum);
    end
    checks++;
    if (b0.out_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_out_count got=%0d exp=0", b0.out_count);
    end
    checks++;
    if (b0.out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_ovf got=%b exp=0", b0.out_ovf);
    end
    rst = 0;
  endtask

  task automatic test_basic();
    logic [31:0] v[4];
    logic [39:0] exp;
    b0.out_ready = 1;
    for (int g = 0; g < 4; g++) begin
      exp = '0;
      for (int i = 0; i < 4; i++) begin
        v[i] = (g == 0) ? 32'(16 * (i + 1)) : $urandom;
        exp = exp + 40'(v[i]);
      end
      for (int i = 0; i < 4; i++) begin
        b0.in_valid = 1;
        b0.in_product = v[i];
        tick();
      end
      b0.in_valid = 0;
      checks++;
      if (b0.out_valid !== 1'b1) begin
        failures++;
        $display("FAIL basic_valid g=%0d got=%b exp=1", g, b0.out_valid);
      end
      checks++;
      if (b0.out_sum !== exp) begin
        failures++;
        $display("FAIL basic_sum g=%0d got=%h exp=%h", g, b0.out_sum, exp);
      end
      checks++;
      if (b0.out_count !== 3'd4) begin
        failures++;
        $display("FAIL basic_count g=%0d got=%0d exp=4", g, b0.out_count);
      end
      checks++;
      if (b0.out_ovf !== 1'b0) begin
        failures++;
        $display("FAIL basic_ovf g=%0d got=%b exp=0", g, b0.out_ovf);
      end
      checks++;
      if (b0.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL basic_rdy_hold g=%0d got=%b exp=0", g, b0.in_ready);
      end
      tick();
      checks++;
      if (b0.in_ready !== 1'b1 || b0.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL basic_release g=%0d rdy=%b vld=%b exp=1,0",
                 g, b0.in_ready, b0.out_valid);
      end
    end
    b0.out_ready = 0;
  endtask

  task automatic test_backpressure();
    b0.out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      b0.in_valid = 1;
      b0.in_product = 32'(16 * (i + 1));
      tick();
    end
    b0.in_product = 32'h55;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (b0.out_valid !== 1'b1 || b0.out_sum !== 40'hA0) begin
        failures++;
        $display("FAIL bp_hold k=%0d vld=%b sum=%h exp=1,a0",
                 k, b0.out_valid, b0.out_sum);
      end
      checks++;
      if (b0.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_in_ready k=%0d got=%b exp=0", k, b0.in_ready);
      end
      tick();
    end
    b0.out_ready = 1;
    tick();
    checks++;
    if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release vld=%b rdy=%b exp=0,1",
               b0.out_valid, b0.in_ready);
    end
    b0.out_ready = 0;
    b0.flush = 1;
    tick();
    checks++;
    if (b0.out_valid !== 1'b1 || b0.out_sum !== 40'h55
        || b0.out_count !== 3'd1) begin
      failures++;
      $display("FAIL bp_new_sum vld=%b sum=%h cnt=%0d exp=1,55,1",
               b0.out_valid, b0.out_sum, b0.out_count);
    end
    b0.flush = 0;
    b0.in_valid = 0;
    b0.out_ready = 1;
    tick();
    b0.out_ready = 0;
  endtask

  task automatic test_flush();
    b0.out_ready = 1;
    b0.in_valid = 1;
    b0.in_product = 32'h7;
    tick();
    b0.in_product = 32'h9;
    tick();
    b0.in_valid = 0;
    b0.flush = 1;
    tick();
    checks++;
    if (b0.out_valid !== 1'b1 || b0.out_sum !== 40'h10
        || b0.out_count !== 3'd2) begin
      failures++;
      $display("FAIL flush_idle vld=%b sum=%h cnt=%0d exp=1,10,2",
               b0.out_valid, b0.out_sum, b0.out_count);
    end
    b0.flush = 0;
    tick();
    b0.in_valid = 1;
    b0.in_product = 32'h2;
    tick();
    b0.in_product = 32'h1;
    b0.flush = 1;
    tick();
    checks++;
    if (b0.out_valid !== 1'b1 || b0.out_sum !== 40'h3
        || b0.out_count !== 3'd2) begin
      failures++;
      $display("FAIL flush_beat vld=%b sum=%h cnt=%0d exp=1,3,2",
               b0.out_valid, b0.out_sum, b0.out_count);
    end
    b0.flush = 0;
    b0.in_valid = 0;
    tick();
    b0.flush = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (b0.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_empty k=%0d got=%b exp=0", k, b0.out_valid);
      end
    end
    b0.flush = 0;
    b0.out_ready = 0;
  endtask

  task automatic test_overflow();
    logic [32:0] maxv;
    logic [32:0] exp;
    longint      s;
    logic [31:0] v[4];
    maxv = '1;
    v = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5};
    s = 0;
    for (int i = 0; i < 4; i++) s += longint'(v[i]);
    exp = (s > longint'(maxv)) ? maxv : s[32:0];
    b1.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      b1.in_valid = 1;
      b1.in_product = v[i];
      tick();
    end
    b1.in_valid = 0;
    checks++;
    if (b1.out_sum !== exp || b1.out_count !== 3'd4) begin
      failures++;
      $display("FAIL ovf_sum sum=%h cnt=%0d exp=%h,4",
               b1.out_sum, b1.out_count, exp);
    end
    checks++;
    if (b1.out_ovf !== (s > longint'(maxv))) begin
      failures++;
      $display("FAIL ovf_flag got=%b exp=1", b1.out_ovf);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      b1.in_valid = 1;
      b1.in_product = 32'h1;
      tick();
    end
    b1.in_valid = 0;
    checks++;
    if (b1.out_sum !== 33'h4 || b1.out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear sum=%h ovf=%b exp=4,0",
               b1.out_sum, b1.out_ovf);
    end
    tick();
    b1.out_ready = 0;
  endtask

  task automatic test_reset_mid();
    b0.out_ready = 1;
    b0.in_valid = 1;
    b0.in_product = 32'h3;
    tick();
    tick();
    b0.in_valid = 0;
    rst = 1;
    tick();
    checks++;
    if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid vld=%b rdy=%b exp=0,1",
               b0.out_valid, b0.in_ready);
    end
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      b0.in_valid = 1;
      b0.in_product = 32'h1;
      tick();
    end
    b0.in_valid = 0;
    b0.out_ready = 0;
    checks++;
    if (b0.out_sum !== 40'h4 || b0.out_count !== 3'd4) begin
      failures++;
      $display("FAIL rst_after sum=%h cnt=%0d exp=4,4",
               b0.out_sum, b0.out_count);
    end
    tick();
    checks++;
    if (b0.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_hold_pre got=%b exp=1", b0.out_valid);
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_hold vld=%b rdy=%b exp=0,1",
               b0.out_valid, b0.in_ready);
    end
  endtask

  task automatic test_random_n4();
    logic [39:0] q_sum[$];
    int          q_cnt[$];
    logic [39:0] g_sum;
    int          g_n;
    int          results;
    int          cyc;
    logic        iv, fl, ordy;
    logic [31:0] p;
    g_sum = '0;
    g_n = 0;
    results = 0;
    cyc = 0;
    while (results < 200 && cyc < 20000) begin
      iv = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 5) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      p = $urandom;
      if (b0.out_valid && ordy) begin
        checks++;
        if (q_sum.size() == 0) begin
          failures++;
          $display("FAIL r4_spurious sum=%h exp=none", b0.out_sum);
        end else begin
          if (b0.out_sum !== q_sum[0]
              || b0.out_count !== 3'(q_cnt[0])
              || b0.out_ovf !== 1'b0) begin
            failures++;
            $display("FAIL r4_result sum=%h cnt=%0d ovf=%b exp=%h,%0d,0",
                     b0.out_sum, b0.out_count, b0.out_ovf,
                     q_sum[0], q_cnt[0]);
          end
          void'(q_sum.pop_front());
          void'(q_cnt.pop_front());
        end
        results++;
      end
      if (b0.in_ready) begin
        if (iv) begin
          g_sum += 40'(p);
          g_n++;
        end
        if (g_n == 4 || (fl && g_n > 0)) begin
          q_sum.push_back(g_sum);
          q_cnt.push_back(g_n);
          g_sum = '0;
          g_n = 0;
        end
      end
      b0.in_valid = iv;
      b0.in_product = p;
      b0.flush = fl;
      b0.out_ready = ordy;
      tick();
      cyc++;
    end
    checks++;
    if (results < 200) begin
      failures++;
      $display("FAIL r4_budget results=%0d exp=200", results);
    end
    b0.in_valid = 0;
    b0.flush = 0;
    b0.out_ready = 0;
  endtask

  task automatic test_n1();
    logic [39:0] q[$];
    int          acc_n;
    int          results;
    int          cyc;
    logic        iv, ordy, prev;
    logic [31:0] p;
    acc_n = 0;
    results = 0;
    cyc = 0;
    prev = 0;
    while ((acc_n < 1000 || q.size() > 0) && cyc < 20000) begin
      iv = (acc_n < 1000) && ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      p = $urandom;
      if (prev) begin
        checks++;
        if (b2.out_valid !== 1'b1) begin
          failures++;
          $display("FAIL n1_latency vld=%b exp=1", b2.out_valid);
        end
      end
      if (b2.out_valid && ordy) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL n1_spurious sum=%h exp=none", b2.out_sum);
        end else begin
          if (b2.out_sum !== q[0] || b2.out_count !== 1'b1) begin
            failures++;
            $display("FAIL n1_result sum=%h cnt=%0d exp=%h,1",
                     b2.out_sum, b2.out_count, q[0]);
          end
          void'(q.pop_front());
        end
        results++;
      end
      prev = iv && b2.in_ready;
      if (prev) begin
        q.push_back(40'(p));
        acc_n++;
      end
      b2.in_valid = iv;
      b2.in_product = p;
      b2.out_ready = ordy;
      tick();
      cyc++;
    end
    checks++;
    if (results != 1000 || acc_n != 1000) begin
      failures++;
      $display("FAIL n1_total results=%0d beats=%0d exp=1000,1000",
               results, acc_n);
    end
    b2.in_valid = 0;
    b2.out_ready = 0;
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_overflow();
    test_reset_mid();
    test_random_n4();
    test_n1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
